// File: rtl/dispatch_stage.sv
// dispatch_stage: registered two-slot in-order dispatch buffer.
// Holds one decoded instruction pair and steers each instruction to the
// lowest-index free reservation-station entry of its class (complex, simple,
// fp). The younger slot never overtakes a blocked older slot. A saturating
// counter records how many cycles the head instruction was blocked.
module dispatch_stage #(
    parameter int DATA_W = 76,
    parameter int N_RS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W+1:0]        in_instA,
    input  logic [DATA_W+1:0]        in_instB,
    input  logic [N_RS-1:0]          complex_empty,
    input  logic [N_RS-1:0]          simple_empty,
    input  logic [N_RS-1:0]          fp_empty,
    output logic [N_RS*DATA_W-1:0]   complex_data,
    output logic [N_RS*DATA_W-1:0]   simple_data,
    output logic [N_RS*DATA_W-1:0]   fp_data,
    output logic [N_RS-1:0]          complex_valid,
    output logic [N_RS-1:0]          simple_valid,
    output logic [N_RS-1:0]          fp_valid,
    output logic                     rs_full_A,
    output logic                     rs_full_B,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int IW = DATA_W + 2;

    localparam logic [1:0] T_BUB = 2'b00;
    localparam logic [1:0] T_CPX = 2'b01;
    localparam logic [1:0] T_FP  = 2'b10;
    localparam logic [1:0] T_SMP = 2'b11;

    // Free-entry mask of the class an instruction type belongs to.
    function automatic logic [N_RS-1:0] f_class_mask(
        input logic [1:0]      t,
        input logic [N_RS-1:0] ce,
        input logic [N_RS-1:0] se,
        input logic [N_RS-1:0] fe
    );
        logic [N_RS-1:0] m;
        case (t)
            T_CPX:   m = ce;
            T_FP:    m = fe;
            T_SMP:   m = se;
            default: m = '0;
        endcase
        return m;
    endfunction

    // One-hot of the lowest set bit; zero when nothing is free.
    function automatic logic [N_RS-1:0] f_lowest(input logic [N_RS-1:0] mask);
        logic [N_RS-1:0] r;
        r = '0;
        for (int i = N_RS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Entries of class cls strobed by a slot that fires with type t.
    function automatic logic [N_RS-1:0] f_own(
        input logic            en,
        input logic [1:0]      t,
        input logic [1:0]      cls,
        input logic [N_RS-1:0] pick
    );
        return (en && (t == cls)) ? pick : '0;
    endfunction

    // Counter increment that sticks at all ones.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Slot state: valid bits are control (reset), instruction words are data.
    logic            r_v0;
    logic            r_v1;
    logic [IW-1:0]   r_inst0;
    logic [IW-1:0]   r_inst1;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]        w_t0;
    logic [1:0]        w_t1;
    logic [DATA_W-1:0] w_p0;
    logic [DATA_W-1:0] w_p1;

    logic [N_RS-1:0] w_pick0;
    logic [N_RS-1:0] w_pick1;
    logic [N_RS-1:0] w_excl;
    logic            w_go0;
    logic            w_go1;
    logic            w_str0;
    logic            w_str1;
    logic            w_acc;

    logic [N_RS-1:0] w_c0, w_c1, w_s0, w_s1, w_f0, w_f1;

    logic            w_v0_n;
    logic            w_v1_n;
    logic [IW-1:0]   w_i0_n;
    logic [IW-1:0]   w_i1_n;

    logic            w_a_nb;
    logic            w_b_nb;

    assign w_t0 = r_inst0[1:0];
    assign w_t1 = r_inst1[1:0];
    assign w_p0 = r_inst0[IW-1:2];
    assign w_p1 = r_inst1[IW-1:2];

    assign w_a_nb = (in_instA[1:0] != T_BUB);
    assign w_b_nb = (in_instB[1:0] != T_BUB);

    // Allocate entries: slot0 first, slot1 from what slot0 left over.
    always_comb begin
        w_pick0 = f_lowest(f_class_mask(w_t0, complex_empty, simple_empty, fp_empty));
        w_excl  = (r_v0 && (w_t1 == w_t0)) ? w_pick0 : '0;
        w_pick1 = f_lowest(f_class_mask(w_t1, complex_empty, simple_empty, fp_empty) & ~w_excl);
    end

    // Slot1 may only go when the older slot is gone or goes with it.
    assign w_go0  = r_v0 && (|w_pick0);
    assign w_go1  = r_v1 && (|w_pick1) && (!r_v0 || w_go0);
    assign w_str0 = w_go0 && !flush;
    assign w_str1 = w_go1 && !flush;

    assign rs_full_A = r_v0 && !w_go0;
    assign rs_full_B = r_v1 && !w_go1;
    assign in_ready  = !flush && (!r_v0 || w_go0) && (!r_v1 || w_go1);
    assign w_acc     = in_valid && in_ready;
    assign stall_cnt = r_cnt;

    assign w_c0 = f_own(w_str0, w_t0, T_CPX, w_pick0);
    assign w_c1 = f_own(w_str1, w_t1, T_CPX, w_pick1);
    assign w_s0 = f_own(w_str0, w_t0, T_SMP, w_pick0);
    assign w_s1 = f_own(w_str1, w_t1, T_SMP, w_pick1);
    assign w_f0 = f_own(w_str0, w_t0, T_FP,  w_pick0);
    assign w_f1 = f_own(w_str1, w_t1, T_FP,  w_pick1);

    assign complex_valid = w_c0 | w_c1;
    assign simple_valid  = w_s0 | w_s1;
    assign fp_valid      = w_f0 | w_f1;

    // Route payloads onto strobed lanes; unstrobed lanes stay zero.
    always_comb begin
        complex_data = '0;
        simple_data  = '0;
        fp_data      = '0;
        for (int i = 0; i < N_RS; i++) begin
            if (w_c0[i])      complex_data[i*DATA_W +: DATA_W] = w_p0;
            else if (w_c1[i]) complex_data[i*DATA_W +: DATA_W] = w_p1;
            if (w_s0[i])      simple_data[i*DATA_W +: DATA_W]  = w_p0;
            else if (w_s1[i]) simple_data[i*DATA_W +: DATA_W]  = w_p1;
            if (w_f0[i])      fp_data[i*DATA_W +: DATA_W]      = w_p0;
            else if (w_f1[i]) fp_data[i*DATA_W +: DATA_W]      = w_p1;
        end
    end

    // Next buffer contents: flush, load (bubbles dropped), shift or drain.
    always_comb begin
        w_v0_n = r_v0;
        w_v1_n = r_v1;
        w_i0_n = r_inst0;
        w_i1_n = r_inst1;
        if (flush) begin
            w_v0_n = 1'b0;
            w_v1_n = 1'b0;
        end else if (w_acc) begin
            if (w_a_nb && w_b_nb) begin
                w_i0_n = in_instA;
                w_i1_n = in_instB;
                w_v0_n = 1'b1;
                w_v1_n = 1'b1;
            end else if (w_a_nb) begin
                w_i0_n = in_instA;
                w_v0_n = 1'b1;
                w_v1_n = 1'b0;
            end else if (w_b_nb) begin
                w_i0_n = in_instB;
                w_v0_n = 1'b1;
                w_v1_n = 1'b0;
            end else begin
                w_v0_n = 1'b0;
                w_v1_n = 1'b0;
            end
        end else if (w_go0 && r_v1 && !w_go1) begin
            w_i0_n = r_inst1;
            w_v0_n = 1'b1;
            w_v1_n = 1'b0;
        end else if ((!r_v0 || w_go0) && (!r_v1 || w_go1)) begin
            w_v0_n = 1'b0;
            w_v1_n = 1'b0;
        end
    end

    // Slot valid bits; reset drops any in-flight instructions at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else begin
            r_v0 <= w_v0_n;
            r_v1 <= w_v1_n;
        end
    end

    // Instruction words; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        r_inst0 <= w_i0_n;
        r_inst1 <= w_i1_n;
    end

    // Count head-blocked cycles, ignoring flush cycles; kept across flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (rs_full_A && !flush) begin
            r_cnt <= f_sat_inc(r_cnt);
        end
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// Testbench for dispatch_stage: table of single-pair vectors checked through
// an expectation queue, plus hand-written multi-cycle sequences.
module tb_dispatch_stage;

    localparam int DW = 8;
    localparam int NR = 2;
    localparam int CW = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DW+1:0]     in_instA;
    logic [DW+1:0]     in_instB;
    logic [NR-1:0]     complex_empty;
    logic [NR-1:0]     simple_empty;
    logic [NR-1:0]     fp_empty;
    logic [NR*DW-1:0]  complex_data;
    logic [NR*DW-1:0]  simple_data;
    logic [NR*DW-1:0]  fp_data;
    logic [NR-1:0]     complex_valid;
    logic [NR-1:0]     simple_valid;
    logic [NR-1:0]     fp_valid;
    logic              rs_full_A;
    logic              rs_full_B;
    logic [CW-1:0]     stall_cnt;

    dispatch_stage #(.DATA_W(DW), .N_RS(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instA(in_instA), .in_instB(in_instB),
        .complex_empty(complex_empty), .simple_empty(simple_empty), .fp_empty(fp_empty),
        .complex_data(complex_data), .simple_data(simple_data), .fp_data(fp_data),
        .complex_valid(complex_valid), .simple_valid(simple_valid), .fp_valid(fp_valid),
        .rs_full_A(rs_full_A), .rs_full_B(rs_full_B), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ta;
        logic [7:0]  pa;
        logic [1:0]  tb;
        logic [7:0]  pb;
        logic [1:0]  ce, se, fe;
        logic [1:0]  cv, sv, fv;
        logic [15:0] cd, sd, fd;
        logic        fa, fb, rdy;
    } vec_t;

    vec_t vecs[13];
    vec_t q[$];
    vec_t e;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm,
                            input logic [1:0] cv, input logic [1:0] sv, input logic [1:0] fv,
                            input logic [15:0] cd, input logic [15:0] sd, input logic [15:0] fd,
                            input logic fa, input logic fb, input logic rdy);
        chk({nm, ".complex_valid"}, 32'(complex_valid), 32'(cv));
        chk({nm, ".simple_valid"},  32'(simple_valid),  32'(sv));
        chk({nm, ".fp_valid"},      32'(fp_valid),      32'(fv));
        chk({nm, ".complex_data"},  32'(complex_data),  32'(cd));
        chk({nm, ".simple_data"},   32'(simple_data),   32'(sd));
        chk({nm, ".fp_data"},       32'(fp_data),       32'(fd));
        chk({nm, ".rs_full_A"},     32'(rs_full_A),     32'(fa));
        chk({nm, ".rs_full_B"},     32'(rs_full_B),     32'(fb));
        chk({nm, ".in_ready"},      32'(in_ready),      32'(rdy));
    endtask

    task automatic offer(input logic [1:0] ta, input logic [7:0] pa,
                         input logic [1:0] tb, input logic [7:0] pb);
        in_instA = {pa, ta};
        in_instB = {pb, tb};
        in_valid = 1'b1;
    endtask

    // Watchdog: the run is a fixed number of cycles, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // type codes: 00 bubble, 01 complex, 10 fp, 11 simple
        //          ta    pa     tb    pb     ce    se    fe    cv    sv    fv    cd        sd        fd        fa    fb    rdy
        vecs[0]  = '{2'b11,8'h01,2'b11,8'h02,2'b11,2'b11,2'b11,2'b00,2'b11,2'b00,16'h0000,16'h0201,16'h0000,1'b0,1'b0,1'b1};
        vecs[1]  = '{2'b01,8'h11,2'b01,8'h22,2'b10,2'b11,2'b11,2'b10,2'b00,2'b00,16'h1100,16'h0000,16'h0000,1'b0,1'b1,1'b0};
        vecs[2]  = '{2'b10,8'h33,2'b11,8'h44,2'b11,2'b11,2'b00,2'b00,2'b00,2'b00,16'h0000,16'h0000,16'h0000,1'b1,1'b1,1'b0};
        vecs[3]  = '{2'b00,8'h00,2'b01,8'h05,2'b11,2'b11,2'b11,2'b01,2'b00,2'b00,16'h0005,16'h0000,16'h0000,1'b0,1'b0,1'b1};
        vecs[4]  = '{2'b00,8'h3C,2'b00,8'h4D,2'b11,2'b11,2'b11,2'b00,2'b00,2'b00,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b1};
        vecs[5]  = '{2'b01,8'h66,2'b10,8'h77,2'b01,2'b11,2'b10,2'b01,2'b00,2'b10,16'h0066,16'h0000,16'h7700,1'b0,1'b0,1'b1};
        vecs[6]  = '{2'b10,8'h12,2'b10,8'h34,2'b11,2'b11,2'b11,2'b00,2'b00,2'b11,16'h0000,16'h0000,16'h3412,1'b0,1'b0,1'b1};
        vecs[7]  = '{2'b11,8'h9A,2'b01,8'hBC,2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,16'h0000,16'h0000,16'h0000,1'b1,1'b1,1'b0};
        vecs[8]  = '{2'b01,8'h0F,2'b00,8'hEE,2'b11,2'b11,2'b11,2'b01,2'b00,2'b00,16'h000F,16'h0000,16'h0000,1'b0,1'b0,1'b1};
        vecs[9]  = '{2'b11,8'hAA,2'b11,8'hBB,2'b11,2'b01,2'b11,2'b00,2'b01,2'b00,16'h0000,16'h00AA,16'h0000,1'b0,1'b1,1'b0};
        vecs[10] = '{2'b10,8'hC1,2'b01,8'hD2,2'b00,2'b11,2'b01,2'b00,2'b00,2'b01,16'h0000,16'h0000,16'h00C1,1'b0,1'b1,1'b0};
        vecs[11] = '{2'b01,8'h01,2'b11,8'h02,2'b10,2'b10,2'b11,2'b10,2'b10,2'b00,16'h0100,16'h0200,16'h0000,1'b0,1'b0,1'b1};
        vecs[12] = '{2'b01,8'h21,2'b01,8'h43,2'b11,2'b11,2'b11,2'b11,2'b00,2'b00,16'h4321,16'h0000,16'h0000,1'b0,1'b0,1'b1};

        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instA = '0;
        in_instB = '0;
        complex_empty = 2'b11;
        simple_empty = 2'b11;
        fp_empty = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_outs("reset", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);

        // Table: accept a pair with all entries free, then present the
        // vector's empty masks in the dispatch cycle; flush to clear.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            offer(vecs[i].ta, vecs[i].pa, vecs[i].tb, vecs[i].pb);
            complex_empty = 2'b11;
            simple_empty = 2'b11;
            fp_empty = 2'b11;
            #1;
            chk($sformatf("vec%0d.accept_ready", i), 32'(in_ready), 32'd1);
            q.push_back(vecs[i]);
            @(negedge clk);
            in_valid = 1'b0;
            complex_empty = vecs[i].ce;
            simple_empty = vecs[i].se;
            fp_empty = vecs[i].fe;
            #1;
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL vec%0d.queue: got empty expected entry", i);
            end else begin
                e = q.pop_front();
                chk_outs($sformatf("vec%0d", i), e.cv, e.sv, e.fv, e.cd, e.sd, e.fd, e.fa, e.fb, e.rdy);
            end
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        chk("table.stall_cnt", 32'(stall_cnt), 32'd0);
        complex_empty = 2'b11;
        simple_empty = 2'b11;
        fp_empty = 2'b11;

        // Partial dispatch: A goes to entry 1, B waits then takes entry 0.
        @(negedge clk);
        offer(2'b01, 8'h11, 2'b01, 8'h22);
        complex_empty = 2'b10;
        #1 chk("part.accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk_outs("part.c1", 2'b10, 2'b00, 2'b00, 16'h1100, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        complex_empty = 2'b01;
        #1 chk_outs("part.c2", 2'b01, 2'b00, 2'b00, 16'h0022, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        complex_empty = 2'b11;
        #1 chk_outs("part.c3", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Blocked head: fp has nothing free, simple behind it must wait.
        @(negedge clk);
        offer(2'b10, 8'h33, 2'b11, 8'h44);
        fp_empty = 2'b00;
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk_outs("stall.c0", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
        chk("stall.cnt0", 32'(stall_cnt), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1 chk($sformatf("stall.cnt%0d", k), 32'(stall_cnt), 32'(k));
            chk($sformatf("stall.fullA%0d", k), 32'(rs_full_A), 32'd1);
        end
        fp_empty = 2'b01;
        #1 chk_outs("stall.go", 2'b00, 2'b01, 2'b01, 16'h0, 16'h0044, 16'h0033, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        fp_empty = 2'b11;
        #1 chk_outs("stall.after", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("stall.cnt_hold", 32'(stall_cnt), 32'd3);

        // Flush while the head is blocked: counter kept, buffer emptied.
        @(negedge clk);
        offer(2'b10, 8'h55, 2'b00, 8'h00);
        fp_empty = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("flush.fullA", 32'(rs_full_A), 32'd1);
        chk("flush.cnt_pre", 32'(stall_cnt), 32'd3);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush.ready", 32'(in_ready), 32'd0);
        chk("flush.cnt_mid", 32'(stall_cnt), 32'd4);
        @(negedge clk);
        flush = 1'b0;
        fp_empty = 2'b01;
        #1 chk_outs("flush.after", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("flush.cnt_kept", 32'(stall_cnt), 32'd4);
        fp_empty = 2'b11;

        // Flush in a cycle that would otherwise dispatch: strobes forced low.
        @(negedge clk);
        offer(2'b11, 8'h01, 2'b11, 8'h02);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1 chk_outs("flushdisp.c", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk_outs("flushdisp.n", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Flush together with in_valid: the pair is refused.
        @(negedge clk);
        offer(2'b01, 8'h09, 2'b00, 8'h00);
        flush = 1'b1;
        #1 chk("flushval.ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1 chk_outs("flushval.n", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges clears the counter.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("arst.cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation: head blocked for 20 cycles on a 4-bit counter.
        @(negedge clk);
        offer(2'b01, 8'h77, 2'b00, 8'h00);
        complex_empty = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1 chk($sformatf("sat.cnt%0d", k), 32'(stall_cnt), 32'((k < 15) ? k : 15));
        end
        complex_empty = 2'b01;
        #1 chk_outs("sat.go", 2'b01, 2'b00, 2'b00, 16'h0077, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        #1 rst = 1'b1;
        #1 chk_outs("sat.rst", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("sat.rst_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_outs("sat.lost", 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
